// File: rtl/pipe5_core.sv
// Five-stage integer pipeline (IF, ID, EX, MEM, WB) with a 16-entry register file,
// internal data memory, full forwarding, load-use interlock, branch flush and HALT.
module pipe5_core #(
  parameter int XLEN       = 32,
  parameter int PC_W       = 16,
  parameter int DMEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] pc_o,
  input  logic [31:0]     instr_i,
  input  logic            instr_valid_i,
  output logic            retire_valid_o,
  output logic [3:0]      retire_rd_o,
  output logic [XLEN-1:0] retire_data_o,
  output logic            halted_o
);

  localparam int AW = $clog2(DMEM_DEPTH);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hB;

  // ADDI, LW and SW all compute rs1+imm through the default arm.
  function automatic logic signed [XLEN-1:0] alu(
    input logic [3:0]             op,
    input logic signed [XLEN-1:0] a,
    input logic signed [XLEN-1:0] b,
    input logic signed [XLEN-1:0] imm
  );
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      OP_SLT:  alu = (a < b) ? XLEN'(1) : '0;
      default: alu = a + imm;
    endcase
  endfunction

  logic [PC_W-1:0] pc_q;
  logic            halt_pend;
  logic            halted_q;

  logic            vld_p1;
  logic [31:0]     instr_p1;
  logic [PC_W-1:0] pc_p1;

  logic                   vld_p2;
  logic [3:0]             op_p2, rd_p2, rs1_p2, rs2_p2;
  logic                   use1_p2, use2_p2, we_p2;
  logic signed [XLEN-1:0] a_p2, b_p2;
  logic [15:0]            imm16_p2;
  logic [PC_W-1:0]        pc_p2;

  logic                   vld_p3;
  logic                   we_p3, ld_p3, st_p3, halt_p3;
  logic [3:0]             rd_p3;
  logic signed [XLEN-1:0] res_p3, sd_p3;

  logic                   rv_p4;
  logic [3:0]             rd_p4;
  logic [XLEN-1:0]        res_p4;

  logic [XLEN-1:0] rf   [16];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];

  // ---- ID: decode, register read (write-first), hazard detection ----
  logic [3:0]             op_d, rd_d, rs1_d, rs2_d;
  logic                   use1_d, use2_d, we_d, halt_d, ld_use;
  logic signed [XLEN-1:0] rs1_val_d, rs2_val_d;

  assign op_d  = instr_p1[31:28];
  assign rd_d  = instr_p1[27:24];
  assign rs1_d = instr_p1[23:20];
  assign rs2_d = instr_p1[19:16];

  always_comb begin
    use1_d = (op_d >= OP_ADD) && (op_d <= OP_BEQ);
    use2_d = ((op_d >= OP_ADD) && (op_d <= OP_SLT)) || (op_d == OP_SW) || (op_d == OP_BEQ);
    we_d   = (op_d >= OP_ADD) && (op_d <= OP_LW);
    halt_d = vld_p1 && (op_d == OP_HALT);

    rs1_val_d = '0;
    if (rs1_d != 4'd0)
      rs1_val_d = (rv_p4 && rd_p4 == rs1_d) ? res_p4 : rf[rs1_d];
    rs2_val_d = '0;
    if (rs2_d != 4'd0)
      rs2_val_d = (rv_p4 && rd_p4 == rs2_d) ? res_p4 : rf[rs2_d];

    ld_use = vld_p2 && (op_p2 == OP_LW) && (rd_p2 != 4'd0) && vld_p1 &&
             ((use1_d && rs1_d == rd_p2) || (use2_d && rs2_d == rd_p2));
  end

  // ---- EX: forwarding, ALU, branch resolution ----
  logic                   fwd3_ok;
  logic signed [XLEN-1:0] a_x, b_x, res_x;
  logic                   br_taken;
  logic [PC_W-1:0]        br_tgt;

  always_comb begin
    fwd3_ok = vld_p3 && we_p3 && !ld_p3 && (rd_p3 != 4'd0);

    if (use1_p2 && fwd3_ok && rd_p3 == rs1_p2)     a_x = res_p3;
    else if (use1_p2 && rv_p4 && rd_p4 == rs1_p2)  a_x = res_p4;
    else                                           a_x = a_p2;

    if (use2_p2 && fwd3_ok && rd_p3 == rs2_p2)     b_x = res_p3;
    else if (use2_p2 && rv_p4 && rd_p4 == rs2_p2)  b_x = res_p4;
    else                                           b_x = b_p2;

    res_x    = alu(op_p2, a_x, b_x, XLEN'($signed(imm16_p2)));
    br_taken = vld_p2 && (op_p2 == OP_BEQ) && (a_x == b_x);
    br_tgt   = pc_p2 + PC_W'(1) + PC_W'($signed(imm16_p2));
  end

  // ---- IF: PC and IF/ID (p1) ----
  logic fetch_ok;
  assign fetch_ok = instr_valid_i && !halt_d && !halt_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      vld_p1    <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      if (br_taken) begin
        pc_q   <= br_tgt;
        vld_p1 <= 1'b0;
      end else if (!ld_use) begin
        vld_p1 <= fetch_ok;
        if (fetch_ok) pc_q <= pc_q + PC_W'(1);
      end
      if (halt_d && !br_taken) halt_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!br_taken && !ld_use && fetch_ok) begin
      instr_p1 <= instr_i;
      pc_p1    <= pc_q;
    end
  end

  // ---- ID/EX (p2) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p2 <= 1'b0;
    else       vld_p2 <= vld_p1 && !br_taken && !ld_use;
  end

  always_ff @(posedge clk) begin
    op_p2    <= op_d;
    rd_p2    <= rd_d;
    rs1_p2   <= rs1_d;
    rs2_p2   <= rs2_d;
    use1_p2  <= use1_d;
    use2_p2  <= use2_d;
    we_p2    <= we_d;
    a_p2     <= rs1_val_d;
    b_p2     <= rs2_val_d;
    imm16_p2 <= instr_p1[15:0];
    pc_p2    <= pc_p1;
  end

  // ---- EX/MEM (p3) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p3 <= 1'b0;
    else       vld_p3 <= vld_p2;
  end

  always_ff @(posedge clk) begin
    we_p3   <= we_p2;
    ld_p3   <= (op_p2 == OP_LW);
    st_p3   <= (op_p2 == OP_SW);
    halt_p3 <= (op_p2 == OP_HALT);
    rd_p3   <= rd_p2;
    res_p3  <= res_x;
    sd_p3   <= b_x;
  end

  // ---- MEM: data memory access ----
  logic [XLEN-1:0] wb_val;
  assign wb_val = ld_p3 ? dmem[res_p3[AW-1:0]] : res_p3;

  always_ff @(posedge clk) begin
    if (vld_p3 && st_p3) dmem[res_p3[AW-1:0]] <= sd_p3;
  end

  // ---- MEM/WB (p4): doubles as the registered retire port ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv_p4    <= 1'b0;
      rd_p4    <= '0;
      res_p4   <= '0;
      halted_q <= 1'b0;
    end else begin
      rv_p4    <= vld_p3 && we_p3 && (rd_p3 != 4'd0);
      rd_p4    <= rd_p3;
      res_p4   <= wb_val;
      halted_q <= halted_q || (vld_p3 && halt_p3);
    end
  end

  // ---- WB: register file write ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (rv_p4) begin
      rf[rd_p4] <= res_p4;
    end
  end

  assign pc_o           = pc_q;
  assign retire_valid_o = rv_p4;
  assign retire_rd_o    = rd_p4;
  assign retire_data_o  = res_p4;
  assign halted_o       = halted_q;

endmodule

// File: tb/tb_pipe5_core.sv
// Directed bench for pipe5_core: forwarding, load-use, branch, r0/fetch gaps,
// HALT, mid-run reset and ALU ops, with per-cycle logs of the observable outputs.
module tb_pipe5_core;
  localparam int XLEN = 32;
  localparam int PC_W = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [PC_W-1:0] pc_o;
  logic [31:0]     instr_i;
  logic            instr_valid_i = 1'b0;
  logic            retire_valid_o;
  logic [3:0]      retire_rd_o;
  logic [XLEN-1:0] retire_data_o;
  logic            halted_o;

  logic [31:0] imem [64];

  pipe5_core #(.XLEN(XLEN), .PC_W(PC_W), .DMEM_DEPTH(256)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_o           (pc_o),
    .instr_i        (instr_i),
    .instr_valid_i  (instr_valid_i),
    .retire_valid_o (retire_valid_o),
    .retire_rd_o    (retire_rd_o),
    .retire_data_o  (retire_data_o),
    .halted_o       (halted_o)
  );

  always #5 clk = ~clk;
  assign instr_i = imem[pc_o[5:0]];

  logic        rv_log [32];
  logic [3:0]  rd_log [32];
  logic [31:0] d_log  [32];
  logic [15:0] pc_log [32];
  logic        h_log  [32];

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ret(input string tag, input int c, input logic [3:0] rd, input logic [31:0] d);
    chk(tag, {27'd0, rv_log[c], rd_log[c], d_log[c]}, {27'd0, 1'b1, rd, d});
  endtask

  task automatic chk_none(input string tag, input int c);
    chk(tag, {63'd0, rv_log[c]}, 64'd0);
  endtask

  task automatic count_rd(input logic [3:0] rd, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++)
      if (rv_log[i] && rd_log[i] == rd) cnt++;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
  endtask

  task automatic start();
    @(negedge clk);
    reset = 1'b1;
    instr_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at the negedge that begins cycle 0; bit i of vmask drives instr_valid_i in cycle i.
  task automatic run(input int n, input logic [31:0] vmask);
    for (int i = 0; i < n; i++) begin
      instr_valid_i = vmask[i];
      rv_log[i] = retire_valid_o;
      rd_log[i] = retire_rd_o;
      d_log[i]  = retire_data_o;
      pc_log[i] = pc_o;
      h_log[i]  = halted_o;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    clear_prog();
    #1 reset = 1'b1;
    #1;
    chk("rst_pc", pc_o, 0);
    chk("rst_rv", retire_valid_o, 0);
    chk("rst_rd", retire_rd_o, 0);
    chk("rst_data", retire_data_o, 0);
    chk("rst_halt", halted_o, 0);

    // Forwarding chain
    clear_prog();
    imem[0] = enc(4'h7, 4'd1, 4'd0, 4'd0, 16'd5);
    imem[1] = enc(4'h1, 4'd2, 4'd1, 4'd1, 16'd0);
    imem[2] = enc(4'h2, 4'd3, 4'd2, 4'd1, 16'd0);
    start();
    run(10, '1);
    chk_none("fwd_c3", 3);
    chk_ret("fwd_r1", 4, 4'd1, 32'd5);
    chk_ret("fwd_r2", 5, 4'd2, 32'd10);
    chk_ret("fwd_r3", 6, 4'd3, 32'd5);
    chk_none("fwd_c7", 7);

    // Load-use interlock
    clear_prog();
    imem[0] = enc(4'h7, 4'd1, 4'd0, 4'd0, 16'd7);
    imem[1] = enc(4'h9, 4'd0, 4'd0, 4'd1, 16'd3);
    imem[2] = enc(4'h8, 4'd2, 4'd0, 4'd0, 16'd3);
    imem[3] = enc(4'h1, 4'd4, 4'd2, 4'd2, 16'd0);
    start();
    run(12, '1);
    chk_ret("lu_r1", 4, 4'd1, 32'd7);
    chk_none("lu_sw", 5);
    chk_ret("lu_lw", 6, 4'd2, 32'd7);
    chk_none("lu_bubble", 7);
    chk_ret("lu_add", 8, 4'd4, 32'd14);
    chk("lu_pc_hold", pc_log[5], 4);

    // Taken branch
    clear_prog();
    imem[0] = enc(4'hA, 4'd0, 4'd0, 4'd0, 16'd2);
    imem[1] = enc(4'h7, 4'd5, 4'd0, 4'd0, 16'd1);
    imem[2] = enc(4'h7, 4'd5, 4'd0, 4'd0, 16'd1);
    imem[3] = enc(4'h7, 4'd6, 4'd0, 4'd0, 16'd9);
    start();
    run(12, '1);
    chk("br_pc_tgt", pc_log[3], 3);
    chk_none("br_c6", 6);
    chk_ret("br_r6", 7, 4'd6, 32'd9);
    count_rd(4'd5, 12, cnt);
    chk("br_r5_count", cnt, 0);

    // r0 write and fetch gap
    clear_prog();
    imem[0] = enc(4'h7, 4'd0, 4'd0, 4'd0, 16'd3);
    imem[1] = enc(4'h1, 4'd1, 4'd0, 4'd0, 16'd0);
    start();
    run(10, 32'hFFFF_FFF9);
    chk_none("gap_r0", 4);
    chk("gap_pc1", pc_log[1], 1);
    chk("gap_pc3", pc_log[3], 1);
    chk("gap_pc4", pc_log[4], 2);
    chk_ret("gap_r1", 7, 4'd1, 32'd0);
    count_rd(4'd1, 10, cnt);
    chk("gap_r1_count", cnt, 1);

    // r0 result directly ahead of a consumer is never forwarded
    clear_prog();
    imem[0] = enc(4'h7, 4'd0, 4'd0, 4'd0, 16'd3);
    imem[1] = enc(4'h1, 4'd1, 4'd0, 4'd0, 16'd0);
    start();
    run(8, '1);
    chk_none("r0b_none", 4);
    chk_ret("r0b_r1", 5, 4'd1, 32'd0);

    // HALT
    clear_prog();
    imem[0] = enc(4'h7, 4'd1, 4'd0, 4'd0, 16'd1);
    imem[1] = enc(4'hB, 4'd0, 4'd0, 4'd0, 16'd0);
    imem[2] = enc(4'h7, 4'd2, 4'd0, 4'd0, 16'd2);
    start();
    run(14, '1);
    chk_ret("halt_r1", 4, 4'd1, 32'd1);
    chk("halt_c4", h_log[4], 0);
    chk("halt_c5", h_log[5], 1);
    chk("halt_c13", h_log[13], 1);
    chk("halt_pc2", pc_log[2], 2);
    chk("halt_pc13", pc_log[13], 2);
    count_rd(4'd2, 14, cnt);
    chk("halt_r2_count", cnt, 0);

    // ALU ops and a not-taken branch
    clear_prog();
    imem[0] = enc(4'h7, 4'd1, 4'd0, 4'd0, 16'hFFFD);
    imem[1] = enc(4'h7, 4'd2, 4'd0, 4'd0, 16'd6);
    imem[2] = enc(4'h3, 4'd3, 4'd1, 4'd2, 16'd0);
    imem[3] = enc(4'h4, 4'd4, 4'd1, 4'd2, 16'd0);
    imem[4] = enc(4'h5, 4'd5, 4'd1, 4'd2, 16'd0);
    imem[5] = enc(4'h6, 4'd6, 4'd1, 4'd2, 16'd0);
    imem[6] = enc(4'h6, 4'd7, 4'd2, 4'd1, 16'd0);
    imem[7] = enc(4'hA, 4'd0, 4'd1, 4'd2, 16'd5);
    imem[8] = enc(4'h7, 4'd8, 4'd0, 4'd0, 16'd8);
    start();
    run(16, '1);
    chk_ret("alu_addi_neg", 4, 4'd1, 32'hFFFF_FFFD);
    chk_ret("alu_and", 6, 4'd3, 32'd4);
    chk_ret("alu_or", 7, 4'd4, 32'hFFFF_FFFF);
    chk_ret("alu_xor", 8, 4'd5, 32'hFFFF_FFFB);
    chk_ret("alu_slt1", 9, 4'd6, 32'd1);
    chk_ret("alu_slt0", 10, 4'd7, 32'd0);
    chk_none("alu_beq", 11);
    chk_ret("alu_nt_r8", 12, 4'd8, 32'd8);

    // Reset in the middle of a hazard-free stream
    clear_prog();
    imem[0] = enc(4'h7, 4'd1, 4'd0, 4'd0, 16'd1);
    imem[1] = enc(4'h7, 4'd2, 4'd0, 4'd0, 16'd2);
    imem[2] = enc(4'h7, 4'd3, 4'd0, 4'd0, 16'd3);
    imem[3] = enc(4'h7, 4'd4, 4'd0, 4'd0, 16'd4);
    start();
    run(4, '1);
    chk("mr_pre_rv", retire_valid_o, 1);
    reset = 1'b1;
    #1;
    chk("mr_pc", pc_o, 0);
    chk("mr_rv", retire_valid_o, 0);
    chk("mr_rd", retire_rd_o, 0);
    chk("mr_data", retire_data_o, 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("mr_hold_rv", retire_valid_o, 0);
      chk("mr_hold_pc", pc_o, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    run(8, '1);
    chk("mr_restart_pc0", pc_log[0], 0);
    chk("mr_restart_pc1", pc_log[1], 1);
    chk_none("mr_c3", 3);
    chk_ret("mr_r1", 4, 4'd1, 32'd1);
    chk_ret("mr_r2", 5, 4'd2, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe5_core.md
# pipe5_core

Parametrised 5-stage pipelined integer datapath (IF, ID, EX, MEM, WB) with a 16-entry register file, internal word-addressed data memory, full operand forwarding, load-use interlock and branch flush. It reads instructions from an external zero-latency instruction memory. It exposes a retire port that the bench and the system use to observe architectural register writes.

## Interface
- XLEN, 32: data path and register width (≥16)
- PC_W, 16: program counter width; PC counts instruction words
- DMEM_DEPTH, 256: data memory depth in XLEN words (power of two)
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- pc_o  out  PC_W  fetch address; instr_i must return mem[pc_o] in the same cycle
- instr_i  in  32  instruction word for pc_o
- instr_valid_i  in  1  instr_i is valid this cycle
- retire_valid_o  out  1  register write committed this cycle
- retire_rd_o  out  4  destination register of the write
- retire_data_o  out  XLEN  value written
- halted_o  out  1  HALT has retired; core is frozen

## Operation
- Encoding: [31:28] op, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm. imm is sign-extended to XLEN for ALU/address use and to PC_W for branches.
- Ops:
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6 SLT (signed, result 0/1); 7 ADDI rd=rs1+imm.
  - 8 LW rd=dmem[rs1+imm]; 9 SW dmem[rs1+imm]=rs2.
  - A BEQ: if rs1==rs2 then pc=pc_branch+1+imm.
  - B HALT.
  - C–F decode as NOP.
- Arithmetic is modulo 2^XLEN. The dmem index is the low log2(DMEM_DEPTH) bits of rs1+imm. The PC wraps modulo 2^PC_W.
- Register file: r0 always reads 0. Writes to r0 are dropped and produce no retire pulse. Reads in ID see a same-cycle WB write (write-first).
- Operand use:
  - rs1 is read by ops 1–A.
  - rs2 is read by ops 1–6, 9 and A.
  - Only ops that read a field take part in forwarding or interlock on it.
- Forwarding into EX (for both rs1 and rs2, including SW store data), in priority order:
  - EX/MEM result (non-load);
  - then MEM/WB result (ALU or load data);
  - then the ID-read value.
  - A source of rd=0 is never forwarded.
- Load-use interlock: the ID instruction reads a used rs that equals the rd≠0 of an LW in EX. Then PC and IF/ID hold for one cycle and a bubble enters EX.
- Branch: resolved in EX. When taken, the IF/ID and ID/EX contents become bubbles and PC takes the target. A branch taken at the same time as a stall takes priority; the stalled instruction is flushed.
- Fetch gaps: instr_valid_i=0 inserts a bubble into IF/ID and holds PC.
- HALT:
  - When HALT is decoded in ID, PC freezes and no further instructions are accepted.
  - Instructions older than HALT complete normally.
  - halted_o rises when HALT reaches WB and stays high until reset.
- Data memory: synchronous write at the end of MEM and combinational read in MEM. Contents are undefined after reset.

## Timing
- Reset values (asynchronous):
  - pc_o=0; all pipeline registers hold bubbles; regfile all 0.
  - retire_valid_o=0, retire_rd_o=0, retire_data_o=0, halted_o=0.
- After reset deasserts, the first fetch is pc_o=0 on the first clock.
- Latency: an instruction presented at cycle n retires (retire_valid_o=1) at cycle n+4. Throughput is 1/cycle with no hazards.
- Load-use costs 1 bubble.
- Taken branch costs 2 bubbles: for a branch fetched at n, pc_o=target at n+3 and the target retires at n+7.
- Retire outputs are registered and valid for exactly one cycle per write.
- Reset mid-operation: every in-flight instruction is discarded and no retire occurs. Stores already committed remain in dmem.

## Test plan
- Forwarding:
  - Stimulus: ADDI r1,r0,5; ADD r2,r1,r1; SUB r3,r2,r1 back-to-back.
  - Response: retires r1=5, r2=10, r3=5 on consecutive cycles 4, 5, 6 with no bubbles.
- Load-use:
  - Stimulus: ADDI r1,r0,7; SW r1,[r0+3]; LW r2,[r0+3]; ADD r4,r2,r2.
  - Response: r4=14; exactly one bubble between the LW and ADD retires.
- Branch:
  - Stimulus: BEQ r0,r0,+2 at pc 0, followed by ADDI r5,r0,1 at pc 1 and pc 2 and ADDI r6,r0,9 at pc 3.
  - Response: r5 never retires; r6=9 retires at cycle 7.
- Register r0 and fetch gaps:
  - Stimulus: ADDI r0,r0,3 with instr_valid_i low for 2 cycles, then ADD r1,r0,r0.
  - Response: no retire for the r0 write; r1=0; PC held during the gap.
- HALT:
  - Stimulus: ADDI r1,r0,1; HALT; ADDI r2,r0,2.
  - Response: r1 retires; halted_o=1 at cycle 5; r2 never retires; pc_o stays at 2.
- Reset mid-run:
  - Stimulus: assert reset during a 4-deep hazard-free stream.
  - Response: outputs immediately take their reset values; there are no retires while reset is high; fetch restarts at pc 0.
